// File: rtl/rx_ptp_parse_pkg.sv
// Shared constants for the XGMII receive-side PTP header parser:
// control codes, EtherTypes, header byte offsets, config bit indices, FSM encodings.
package rx_ptp_parse_pkg;

  localparam logic [7:0]  XGMII_START = 8'hFB;
  localparam logic [7:0]  XGMII_TERM  = 8'hFD;
  localparam logic [7:0]  XGMII_ERR   = 8'hFE;
  localparam logic [7:0]  XGMII_IDLE  = 8'h07;

  localparam logic [15:0] ETYPE_PTP  = 16'h88F7;
  localparam logic [15:0] ETYPE_VLAN = 16'h8100;

  // Byte positions counted from the first DA byte
  localparam logic [11:0] ETYPE_POS      = 12'd12;
  localparam logic [11:0] ETYPE_POS_VLAN = 12'd16;
  localparam logic [11:0] HDR_BASE       = 12'd14;
  localparam logic [11:0] HDR_BASE_VLAN  = 12'd18;

  // Offsets inside the PTP common header
  localparam logic [11:0] OFF_MSGTYPE = 12'd0;
  localparam logic [11:0] OFF_VERSION = 12'd1;
  localparam logic [11:0] OFF_FLAGS   = 12'd6;
  localparam logic [11:0] OFF_SPI     = 12'd20;
  localparam logic [11:0] OFF_SEQID   = 12'd30;
  localparam logic [11:0] OFF_LAST    = 12'd33;

  localparam int unsigned CFG_RX_TS_EN  = 8;
  localparam int unsigned CFG_RX_INT_EN = 9;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HDR      = 2'd1;
  localparam logic [1:0] ST_WAIT_END = 2'd2;

  localparam logic [10:0] CNT_MAX = 11'd2047;

  function automatic logic [10:0] cnt_advance(input logic [10:0] c);
    return (c > CNT_MAX - 11'd8) ? CNT_MAX : c + 11'd8;
  endfunction

endpackage

// File: rtl/rx_xgmii_ctl_det.sv
// Per-lane XGMII control decode: start, terminate and error flags,
// plus the lowest lane carrying a terminate.
module rx_xgmii_ctl_det
  import rx_ptp_parse_pkg::*;
(
  input  logic [63:0] i_rxd,
  input  logic [7:0]  i_rxc,
  output logic [7:0]  o_start,
  output logic [7:0]  o_term,
  output logic [7:0]  o_err,
  output logic        o_term_any,
  output logic [2:0]  o_term_lane
);

  always_comb begin
    o_start     = '0;
    o_term      = '0;
    o_err       = '0;
    o_term_lane = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      o_start[n] = i_rxc[n] && (i_rxd[8*n +: 8] == XGMII_START);
      o_term[n]  = i_rxc[n] && (i_rxd[8*n +: 8] == XGMII_TERM);
      o_err[n]   = i_rxc[n] && (i_rxd[8*n +: 8] == XGMII_ERR);
    end
    for (int unsigned n = 8; n > 0; n--) begin
      if (o_term[n-1]) o_term_lane = 3'(n - 1);
    end
    o_term_any = |o_term;
  end

endmodule

// File: rtl/rx_ptp_parse.sv
// XGMII receive PTP parser: timestamps SFD, extracts PTPv2 header fields, reports on /T/.
// Optional macro RX_PTP_VLAN_EN: skip a single 802.1Q tag before the EtherType check.
module rx_ptp_parse
  import rx_ptp_parse_pkg::*;
(
  input  logic         rx_clk,
  input  logic         rx_rst_n,
  input  logic         rx_clk_en_i,
  input  logic [63:0]  rxd_i,
  input  logic [7:0]   rxc_i,
  output logic [63:0]  rxd_o,
  output logic [7:0]   rxc_o,
  input  logic [79:0]  sfd_timestamp_i,
  input  logic [15:0]  sfd_timestamp_frac_ns_i,
  input  logic [31:0]  tsu_cfg_i,
  output logic         rxts_valid_o,
  output logic [79:0]  rx_timestamp_o,
  output logic [15:0]  rx_timestamp_frac_ns_o,
  output logic [79:0]  rx_sourcePortIdentity_o,
  output logic [15:0]  rx_flagField_o,
  output logic [15:0]  rx_seqId_o,
  output logic [3:0]   rx_messageType_o,
  output logic [3:0]   rx_majorSdoId_o,
  output logic [3:0]   rx_versionPTP_o,
  output logic [3:0]   rx_minorVersionPTP_o,
  output logic         int_rx_ptp_o
);

`ifdef RX_PTP_VLAN_EN
  localparam bit VLAN_SUPPORT = 1'b1;
`else
  localparam bit VLAN_SUPPORT = 1'b0;
`endif

  logic [1:0]  r_state;
  logic [10:0] r_cnt;
  logic        r_vlan;
  logic [79:0] r_sh_ts, r_sh_spi;
  logic [15:0] r_sh_frac, r_sh_flag, r_sh_seq;
  logic [3:0]  r_sh_msg, r_sh_major, r_sh_ver, r_sh_minor;

  logic [7:0]  w_start_l, w_term_l, w_err_l, w_err_mask;
  logic        w_term_any, w_err, w_unused;
  logic [2:0]  w_term_lane;
  logic [1:0]  w_state_n;
  logic        w_begin, w_report, w_vlan_n, w_et_fail, w_hdr_done;
  logic [79:0] w_spi_n;
  logic [15:0] w_flag_n, w_seq_n;
  logic [3:0]  w_msg_n, w_major_n, w_ver_n, w_minor_n;
  logic [11:0] v_idx, v_pos, v_base;
  logic [15:0] v_et;
  logic [7:0]  v_b;

  rx_xgmii_ctl_det u_ctl_det (
    .i_rxd       (rxd_i),
    .i_rxc       (rxc_i),
    .o_start     (w_start_l),
    .o_term      (w_term_l),
    .o_err       (w_err_l),
    .o_term_any  (w_term_any),
    .o_term_lane (w_term_lane)
  );

  // Error codes after the terminate lane belong to the inter-frame gap.
  always_comb begin
    w_err_mask = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      w_err_mask[n] = !w_term_any || (3'(n) < w_term_lane);
    end
  end
  assign w_err    = |(w_err_l & w_err_mask);
  assign w_unused = ^{tsu_cfg_i[31:10], tsu_cfg_i[7:0], w_start_l[7:1]};

  // Header byte extraction; lane n of the current word is byte r_cnt+n.
  always_comb begin
    w_vlan_n   = r_vlan;
    w_spi_n    = r_sh_spi;
    w_flag_n   = r_sh_flag;
    w_seq_n    = r_sh_seq;
    w_msg_n    = r_sh_msg;
    w_major_n  = r_sh_major;
    w_ver_n    = r_sh_ver;
    w_minor_n  = r_sh_minor;
    w_et_fail  = 1'b0;
    w_hdr_done = 1'b0;
    v_idx      = '0;
    v_pos      = '0;
    v_base     = '0;
    v_et       = '0;
    v_b        = '0;
    if (r_state == ST_HDR) begin
      for (int unsigned n = 0; n < 8; n++) begin
        if (!rxc_i[n]) begin
          v_idx  = {1'b0, r_cnt} + 12'(n);
          v_b    = rxd_i[8*n +: 8];
          v_pos  = w_vlan_n ? ETYPE_POS_VLAN : ETYPE_POS;
          v_base = w_vlan_n ? HDR_BASE_VLAN : HDR_BASE;
          if (v_idx == v_pos) v_et[15:8] = v_b;
          if (v_idx == v_pos + 12'd1) begin
            v_et[7:0] = v_b;
            if (VLAN_SUPPORT && !w_vlan_n && (v_et == ETYPE_VLAN)) w_vlan_n = 1'b1;
            else if (v_et != ETYPE_PTP) w_et_fail = 1'b1;
          end
          if (v_idx == v_base + OFF_MSGTYPE) begin
            w_major_n = v_b[7:4];
            w_msg_n   = v_b[3:0];
          end
          if (v_idx == v_base + OFF_VERSION) begin
            w_minor_n = v_b[7:4];
            w_ver_n   = v_b[3:0];
          end
          if (v_idx == v_base + OFF_FLAGS)         w_flag_n[15:8] = v_b;
          if (v_idx == v_base + OFF_FLAGS + 12'd1) w_flag_n[7:0]  = v_b;
          for (int unsigned k = 0; k < 10; k++) begin
            if (v_idx == v_base + OFF_SPI + 12'(k)) w_spi_n[8*(9-k) +: 8] = v_b;
          end
          if (v_idx == v_base + OFF_SEQID)         w_seq_n[15:8] = v_b;
          if (v_idx == v_base + OFF_SEQID + 12'd1) w_seq_n[7:0]  = v_b;
          if (v_idx == v_base + OFF_LAST)          w_hdr_done = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_begin   = 1'b0;
    w_report  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_l[0] && tsu_cfg_i[CFG_RX_TS_EN]) begin
          w_state_n = ST_HDR;
          w_begin   = 1'b1;
        end
      end
      ST_HDR, ST_WAIT_END: begin
        if (w_err) begin
          w_state_n = ST_IDLE;
        end else if (w_start_l[0]) begin
          w_begin   = tsu_cfg_i[CFG_RX_TS_EN];
          w_state_n = tsu_cfg_i[CFG_RX_TS_EN] ? ST_HDR : ST_IDLE;
        end else if (r_state == ST_HDR) begin
          if (w_term_any || w_et_fail) w_state_n = ST_IDLE;
          else if (w_hdr_done)         w_state_n = ST_WAIT_END;
        end else if (w_term_any) begin
          w_state_n = ST_IDLE;
          w_report  = 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_vlan     <= 1'b0;
      r_sh_ts    <= '0;
      r_sh_frac  <= '0;
      r_sh_spi   <= '0;
      r_sh_flag  <= '0;
      r_sh_seq   <= '0;
      r_sh_msg   <= '0;
      r_sh_major <= '0;
      r_sh_ver   <= '0;
      r_sh_minor <= '0;
      rxd_o      <= {8{XGMII_IDLE}};
      rxc_o      <= '1;
      rxts_valid_o            <= 1'b0;
      rx_timestamp_o          <= '0;
      rx_timestamp_frac_ns_o  <= '0;
      rx_sourcePortIdentity_o <= '0;
      rx_flagField_o          <= '0;
      rx_seqId_o              <= '0;
      rx_messageType_o        <= '0;
      rx_majorSdoId_o         <= '0;
      rx_versionPTP_o         <= '0;
      rx_minorVersionPTP_o    <= '0;
    end else begin
      rxts_valid_o <= 1'b0;
      if (rx_clk_en_i) begin
        rxd_o   <= rxd_i;
        rxc_o   <= rxc_i;
        r_state <= w_state_n;
        if (w_begin) begin
          r_cnt      <= '0;
          r_vlan     <= 1'b0;
          r_sh_ts    <= sfd_timestamp_i;
          r_sh_frac  <= sfd_timestamp_frac_ns_i;
          r_sh_spi   <= '0;
          r_sh_flag  <= '0;
          r_sh_seq   <= '0;
          r_sh_msg   <= '0;
          r_sh_major <= '0;
          r_sh_ver   <= '0;
          r_sh_minor <= '0;
        end else if (r_state != ST_IDLE) begin
          r_cnt      <= (w_state_n == ST_IDLE) ? '0 : cnt_advance(r_cnt);
          r_vlan     <= w_vlan_n;
          r_sh_spi   <= w_spi_n;
          r_sh_flag  <= w_flag_n;
          r_sh_seq   <= w_seq_n;
          r_sh_msg   <= w_msg_n;
          r_sh_major <= w_major_n;
          r_sh_ver   <= w_ver_n;
          r_sh_minor <= w_minor_n;
        end
        if (w_report) begin
          rxts_valid_o            <= 1'b1;
          rx_timestamp_o          <= r_sh_ts;
          rx_timestamp_frac_ns_o  <= r_sh_frac;
          rx_sourcePortIdentity_o <= r_sh_spi;
          rx_flagField_o          <= r_sh_flag;
          rx_seqId_o              <= r_sh_seq;
          rx_messageType_o        <= r_sh_msg;
          rx_majorSdoId_o         <= r_sh_major;
          rx_versionPTP_o         <= r_sh_ver;
          rx_minorVersionPTP_o    <= r_sh_minor;
        end
      end
    end
  end

  assign int_rx_ptp_o = rxts_valid_o & tsu_cfg_i[CFG_RX_INT_EN];

endmodule

// File: tb/tb_rx_ptp_parse.sv
// Self-checking bench for rx_ptp_parse: frames built as byte lists, expectations from chosen field values.
module tb_rx_ptp_parse;

  typedef struct packed {
    logic [79:0] ts;
    logic [15:0] frac;
    logic [79:0] spi;
    logic [15:0] flag;
    logic [15:0] seq;
    logic [3:0]  msg, major, ver, minor;
  } fields_t;

  typedef struct {
    logic [15:0] etype;
    bit vlan;
    int err_byte;
    int trunc;
    bit term;
    int gap;
    int rst_word;
    bit lane4;
    bit clr_en;
  } opt_t;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n, rx_clk_en_i;
  logic [63:0] rxd_i, rxd_o;
  logic [7:0]  rxc_i, rxc_o;
  logic [79:0] sfd_timestamp_i, rx_timestamp_o, rx_sourcePortIdentity_o;
  logic [15:0] sfd_timestamp_frac_ns_i, rx_timestamp_frac_ns_o, rx_flagField_o, rx_seqId_o;
  logic [31:0] tsu_cfg_i;
  logic        rxts_valid_o, int_rx_ptp_o;
  logic [3:0]  rx_messageType_o, rx_majorSdoId_o, rx_versionPTP_o, rx_minorVersionPTP_o;

  rx_ptp_parse dut (
    .rx_clk                  (rx_clk),
    .rx_rst_n                (rx_rst_n),
    .rx_clk_en_i             (rx_clk_en_i),
    .rxd_i                   (rxd_i),
    .rxc_i                   (rxc_i),
    .rxd_o                   (rxd_o),
    .rxc_o                   (rxc_o),
    .sfd_timestamp_i         (sfd_timestamp_i),
    .sfd_timestamp_frac_ns_i (sfd_timestamp_frac_ns_i),
    .tsu_cfg_i               (tsu_cfg_i),
    .rxts_valid_o            (rxts_valid_o),
    .rx_timestamp_o          (rx_timestamp_o),
    .rx_timestamp_frac_ns_o  (rx_timestamp_frac_ns_o),
    .rx_sourcePortIdentity_o (rx_sourcePortIdentity_o),
    .rx_flagField_o          (rx_flagField_o),
    .rx_seqId_o              (rx_seqId_o),
    .rx_messageType_o        (rx_messageType_o),
    .rx_majorSdoId_o         (rx_majorSdoId_o),
    .rx_versionPTP_o         (rx_versionPTP_o),
    .rx_minorVersionPTP_o    (rx_minorVersionPTP_o),
    .int_rx_ptp_o            (int_rx_ptp_o)
  );

  always #5 rx_clk = ~rx_clk;

  int unsigned n_pass = 0, n_total = 0, gcnt = 0;
  int          cur_gap = 0;
  logic [63:0] exp_rxd;
  logic [7:0]  exp_rxc;
  logic        exp_valid;
  fields_t     exp_o, cur_f;
  logic [7:0]  q[$];

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.ts    = 80'({$urandom(), $urandom(), $urandom()});
    f.frac  = 16'($urandom());
    f.spi   = 80'({$urandom(), $urandom(), $urandom()});
    f.flag  = 16'($urandom());
    f.seq   = 16'($urandom());
    f.msg   = 4'($urandom());
    f.major = 4'($urandom());
    f.ver   = 4'($urandom());
    f.minor = 4'($urandom());
    return f;
  endfunction

  function automatic opt_t dflt();
    opt_t o;
    o.etype = 16'h88F7; o.vlan = 1'b0; o.err_byte = -1; o.trunc = -1; o.term = 1'b1;
    o.gap = 0; o.rst_word = -1; o.lane4 = 1'b0; o.clr_en = 1'b0;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycle(input logic [63:0] d, input logic [7:0] c, input bit en, input bit rst_n,
                       input bit rep, input logic [79:0] ts, input logic [15:0] fr);
    rxd_i = d; rxc_i = c; rx_clk_en_i = en; rx_rst_n = rst_n;
    sfd_timestamp_i = ts; sfd_timestamp_frac_ns_i = fr;
    @(posedge rx_clk);
    if (!rst_n) begin
      exp_rxd = {8{8'h07}}; exp_rxc = 8'hFF; exp_valid = 1'b0; exp_o = '0;
    end else begin
      exp_valid = en && rep;
      if (en) begin exp_rxd = d; exp_rxc = c; end
      if (en && rep) exp_o = cur_f;
    end
    @(negedge rx_clk);
    chk("rxd_o", 80'(rxd_o), 80'(exp_rxd));
    chk("rxc_o", 80'(rxc_o), 80'(exp_rxc));
    chk("rxts_valid_o", 80'(rxts_valid_o), 80'(exp_valid));
    chk("int_rx_ptp_o", 80'(int_rx_ptp_o), 80'(exp_valid & tsu_cfg_i[9]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle({8{8'h07}}, 8'hFF, 1'b1, 1'b1, 1'b0, 80'(r64()), 16'($urandom()));
  endtask

  task automatic word(input logic [63:0] d, input logic [7:0] c, input bit rep, input bit rst_n,
                      input logic [79:0] ts, input logic [15:0] fr);
    if (cur_gap > 0) begin
      gcnt++;
      if (gcnt % cur_gap == 0) cycle(r64(), 8'h00, 1'b0, 1'b1, 1'b0, 80'(r64()), 16'($urandom()));
    end
    cycle(d, c, 1'b1, rst_n, rep, ts, fr);
  endtask

  task automatic check_fields();
    chk("rx_timestamp_o", rx_timestamp_o, exp_o.ts);
    chk("rx_timestamp_frac_ns_o", 80'(rx_timestamp_frac_ns_o), 80'(exp_o.frac));
    chk("rx_sourcePortIdentity_o", rx_sourcePortIdentity_o, exp_o.spi);
    chk("rx_flagField_o", 80'(rx_flagField_o), 80'(exp_o.flag));
    chk("rx_seqId_o", 80'(rx_seqId_o), 80'(exp_o.seq));
    chk("rx_messageType_o", 80'(rx_messageType_o), 80'(exp_o.msg));
    chk("rx_majorSdoId_o", 80'(rx_majorSdoId_o), 80'(exp_o.major));
    chk("rx_versionPTP_o", 80'(rx_versionPTP_o), 80'(exp_o.ver));
    chk("rx_minorVersionPTP_o", 80'(rx_minorVersionPTP_o), 80'(exp_o.minor));
  endtask

  task automatic send_frame(input fields_t f, input opt_t o);
    int len, hdr_last, idx;
    bit ok_et, rep, cfg_en;
    logic [63:0] d;
    logic [7:0]  c;
    q.delete();
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom()));
    if (o.vlan) begin
      q.push_back(8'h81); q.push_back(8'h00); q.push_back(8'($urandom())); q.push_back(8'($urandom()));
    end
    q.push_back(o.etype[15:8]); q.push_back(o.etype[7:0]);
    q.push_back({f.major, f.msg}); q.push_back({f.minor, f.ver});
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom()));
    q.push_back(f.flag[15:8]); q.push_back(f.flag[7:0]);
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom()));
    for (int k = 0; k < 10; k++) q.push_back(f.spi[79-8*k -: 8]);
    q.push_back(f.seq[15:8]); q.push_back(f.seq[7:0]);
    for (int i = 0; i < 22 + int'($urandom() % 20); i++) q.push_back(8'($urandom()));
    if (o.trunc >= 0) while (q.size() > o.trunc) void'(q.pop_back());
    len = q.size();
    hdr_last = (o.vlan ? 18 : 14) + 33;
`ifdef RX_PTP_VLAN_EN
    ok_et = (o.etype == 16'h88F7);
`else
    ok_et = !o.vlan && (o.etype == 16'h88F7);
`endif
    cfg_en = tsu_cfg_i[8];
    rep = cfg_en && ok_et && (o.err_byte < 0) && o.term && !o.lane4 && (o.rst_word < 0) && (len > hdr_last);
    cur_f = f;
    cur_gap = o.gap;
    if (o.lane4) word({8'hD5, 8'h55, 8'h55, 8'hFB, {4{8'h07}}}, 8'h1F, 1'b0, 1'b1, f.ts, f.frac);
    else         word({8'hD5, {6{8'h55}}, 8'hFB}, 8'h01, 1'b0, 1'b1, f.ts, f.frac);
    if (o.clr_en) tsu_cfg_i[8] = 1'b0;
    for (int w = 0; o.term ? (8*w <= len) : (8*w < len); w++) begin
      for (int l = 0; l < 8; l++) begin
        idx = 8*w + l;
        if (idx < len && idx == o.err_byte) begin d[8*l +: 8] = 8'hFE; c[l] = 1'b1; end
        else if (idx < len)                  begin d[8*l +: 8] = q[idx]; c[l] = 1'b0; end
        else if (idx == len && o.term)       begin d[8*l +: 8] = 8'hFD; c[l] = 1'b1; end
        else                                 begin d[8*l +: 8] = 8'h07; c[l] = 1'b1; end
      end
      word(d, c, rep && o.term && (8*w + 8 > len), (w == o.rst_word) ? 1'b0 : 1'b1,
           80'(r64()), 16'($urandom()));
    end
    cur_gap = 0;
    idle(4);
    tsu_cfg_i[8] = cfg_en;
    check_fields();
  endtask

  initial begin
    fields_t f, fsync;
    opt_t o;
    exp_o = '0;
    tsu_cfg_i = 32'h0000_0300;
    cycle({8{8'h07}}, 8'hFF, 1'b1, 1'b0, 1'b0, '0, '0);
    cycle(r64(), 8'h00, 1'b0, 1'b0, 1'b0, '0, '0);
    check_fields();
    idle(3);

    fsync = rand_fields();
    fsync.seq = 16'h1234; fsync.msg = 4'h0; fsync.ts = 80'h000000000001_3B9AC9FF;
    send_frame(fsync, dflt());

    f = rand_fields(); o = dflt(); o.etype = 16'h0800;
    send_frame(f, o);

    f = rand_fields(); o = dflt(); o.err_byte = 59;
    send_frame(f, o);
    f = rand_fields(); f.msg = 4'h1;
    send_frame(f, dflt());

    o = dflt(); o.gap = 10;
    send_frame(fsync, o);

    f = rand_fields(); o = dflt(); o.vlan = 1'b1;
    send_frame(f, o);

    tsu_cfg_i = 32'h0000_0100;
    send_frame(rand_fields(), dflt());
    tsu_cfg_i = 32'h0000_0200;
    send_frame(rand_fields(), dflt());
    tsu_cfg_i = 32'h0000_0300;
    o = dflt(); o.clr_en = 1'b1;
    send_frame(rand_fields(), o);
    o = dflt(); o.lane4 = 1'b1;
    send_frame(rand_fields(), o);

    o = dflt(); o.trunc = 30; o.term = 1'b0;
    send_frame(rand_fields(), o);
    send_frame(rand_fields(), dflt());

    for (int i = 0; i < 16; i++) begin
      f = rand_fields(); o = dflt();
      o.vlan  = ($urandom() % 3) == 0;
      o.etype = (($urandom() % 4) == 0) ? 16'h0800 : 16'h88F7;
      if (($urandom() % 4) == 0) o.err_byte = (o.vlan ? 52 : 48) + int'($urandom() % 12);
      o.gap = (($urandom() % 2) == 0) ? 0 : 3 + int'($urandom() % 8);
      tsu_cfg_i = $urandom();
      tsu_cfg_i[8] = ($urandom() % 5) != 0;
      send_frame(f, o);
    end

    tsu_cfg_i = 32'h0000_0300;
    o = dflt(); o.rst_word = 2;
    send_frame(rand_fields(), o);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
